// File: rtl/hazard_pkg.sv
// Shared types and defaults for the decode-side hazard controller.
// Combinational decode helpers only; no state lives here.
package hazard_pkg;

    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/scoreboard_regs.sv
// Per-register pending bits: set at issue, cleared at writeback, r0 hardwired clear.
// Updates land one cycle after set/clr; set beats clear on the same register.
module scoreboard_regs
    import hazard_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        // A new producer to the same register is still outstanding.
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard hazard controller beside ID: stalls IF/ID on RAW, flushes IF/ID on taken branch.
// Stall/bubble are combinational from the registered scoreboard; flush is held FLUSH_CYCLES.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG          = DEF_NREG,
    parameter int AW            = DEF_AW,
    parameter int STALL_TIMEOUT = 15,
    parameter int FLUSH_CYCLES  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_wr_addr,
    input  logic            wb_wr_en,
    input  logic [AW-1:0]   wb_wr_addr,
    input  logic            ex_branch_taken,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex,
    output logic            flush_if_id,
    output logic [NREG-1:0] busy_vec,
    output logic            hazard_timeout
);

    localparam int SCW = $clog2(STALL_TIMEOUT + 1);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [SCW-1:0] STALL_MAX  = SCW'(STALL_TIMEOUT);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic            hazard_timeout_q, hazard_timeout_d;

    logic            hazard;
    logic            in_flush;
    logic            stall;
    logic            issue;

    // r0 never has its busy bit set, so reads of r0 fall out of this naturally.
    always_comb begin
        hazard   = id_valid & ((id_rs_used & busy_vec[id_rs]) |
                               (id_rt_used & busy_vec[id_rt]));
        in_flush = (state_q == ST_FLUSH);
        stall    = hazard & ~in_flush & ~ex_branch_taken;
        issue    = id_valid & id_wr_en & ~hazard & ~in_flush & ~ex_branch_taken;
    end

    scoreboard_regs #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue),
        .set_addr (id_wr_addr),
        .clr_en   (wb_wr_en),
        .clr_addr (wb_wr_addr),
        .busy_vec (busy_vec)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (hazard) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (ex_branch_taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (!hazard) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // A second taken branch restarts the flush window.
                if (ex_branch_taken) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + SCW'(1);
        end
        hazard_timeout_d = hazard_timeout_q | (stall_cnt_d == STALL_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            flush_cnt_q      <= '0;
            stall_cnt_q      <= '0;
            hazard_timeout_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
            hazard_timeout_q <= hazard_timeout_d;
        end
    end

    assign stall_if       = stall;
    assign stall_id       = stall;
    assign bubble_ex      = stall;
    assign flush_if_id    = in_flush;
    assign hazard_timeout = hazard_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded bench for pipeline_hazard_ctrl: directed hazard scenarios then random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int TMO   = 15;
    localparam int FLUSH = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            id_valid = 1'b0;
    logic [AW-1:0]   id_rs = '0;
    logic [AW-1:0]   id_rt = '0;
    logic            id_rs_used = 1'b0;
    logic            id_rt_used = 1'b0;
    logic            id_wr_en = 1'b0;
    logic [AW-1:0]   id_wr_addr = '0;
    logic            wb_wr_en = 1'b0;
    logic [AW-1:0]   wb_wr_addr = '0;
    logic            ex_branch_taken = 1'b0;
    logic            stall_if, stall_id, bubble_ex, flush_if_id, hazard_timeout;
    logic [NREG-1:0] busy_vec;

    pipeline_hazard_ctrl #(
        .NREG(NREG), .AW(AW), .STALL_TIMEOUT(TMO), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .ex_branch_taken(ex_branch_taken),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .busy_vec(busy_vec), .hazard_timeout(hazard_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        stall;
        bit        flush;
        bit [31:0] busy;
        bit        tmo;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: pending-writer set, remaining flush cycles, stall run length.
    bit   m_busy[NREG];
    int   m_flush_left = 0;
    int   m_stall_run  = 0;
    bit   m_tmo        = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("stall_if",       32'(stall_if),       32'(mon_e.stall));
            chk("stall_id",       32'(stall_id),       32'(mon_e.stall));
            chk("bubble_ex",      32'(bubble_ex),      32'(mon_e.stall));
            chk("flush_if_id",    32'(flush_if_id),    32'(mon_e.flush));
            chk("busy_vec",       busy_vec,            mon_e.busy);
            chk("hazard_timeout", 32'(hazard_timeout), 32'(mon_e.tmo));
        end
    end

    task automatic step(input bit rst, input bit v, input int rs, input int rt,
                        input bit rsu, input bit rtu, input bit wen, input int wa,
                        input bit wbe, input int wba, input bit br);
        exp_t e;
        bit   hz, flushing, stl, iss;
        @(posedge clk);
        #1;
        reset           = rst;
        id_valid        = v;
        id_rs           = AW'(rs);
        id_rt           = AW'(rt);
        id_rs_used      = rsu;
        id_rt_used      = rtu;
        id_wr_en        = wen;
        id_wr_addr      = AW'(wa);
        wb_wr_en        = wbe;
        wb_wr_addr      = AW'(wba);
        ex_branch_taken = br;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_flush_left = 0;
            m_stall_run  = 0;
            m_tmo        = 1'b0;
            e = '{stall: 1'b0, flush: 1'b0, busy: 32'd0, tmo: 1'b0};
            expq.push_back(e);
            return;
        end
        hz = v && ((rsu && rs != 0 && m_busy[rs]) || (rtu && rt != 0 && m_busy[rt]));
        flushing = (m_flush_left > 0);
        stl = hz && !flushing && !br;
        iss = v && wen && !hz && !flushing && !br;
        e.stall = stl;
        e.flush = flushing;
        e.tmo   = m_tmo;
        e.busy  = '0;
        for (int i = 0; i < NREG; i++) e.busy[i] = m_busy[i];
        expq.push_back(e);
        if (wbe && wba != 0) m_busy[wba] = 1'b0;
        if (iss && wa != 0)  m_busy[wa]  = 1'b1;
        if (br)                    m_flush_left = FLUSH;
        else if (m_flush_left > 0) m_flush_left--;
        m_stall_run = stl ? ((m_stall_run < TMO) ? m_stall_run + 1 : TMO) : 0;
        if (m_stall_run == TMO) m_tmo = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_wr(input int r);
        step(0, 1, 0, 0, 0, 0, 1, r, 0, 0, 0);
    endtask

    task automatic read_rs(input int r, input bit wbe, input int wba);
        step(0, 1, r, 0, 1, 0, 0, 0, wbe, wba, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // RAW on r5: stall through the WB cycle, proceed the cycle after.
        issue_wr(5);
        for (int i = 0; i < 3; i++) read_rs(5, 0, 0);
        read_rs(5, 1, 5);
        read_rs(5, 0, 0);
        idle();

        // r0 writes and reads are invisible to the scoreboard.
        issue_wr(0);
        read_rs(0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        idle();

        // WB clears r7 in the same cycle a new writer to r7 issues.
        issue_wr(7);
        step(0, 1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        idle();

        // Branch resolves while stalled on r3; killed instructions set nothing.
        issue_wr(3);
        read_rs(3, 0, 0);
        read_rs(3, 0, 0);
        step(0, 1, 3, 0, 1, 0, 1, 12, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1, 13, 0, 0, 0);
        step(0, 1, 3, 0, 1, 0, 0, 0, 1, 3, 0);
        idle();
        // Back-to-back branches keep the flush window open.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1, 14, 0, 0, 1);
        idle();
        idle();

        // Watchdog: r9 held busy well past the stall limit.
        issue_wr(9);
        for (int i = 0; i < TMO + 2; i++) step(0, 1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 9, 0, 1, 0, 0, 1, 9, 0);
        step(0, 1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
        idle();
        #2;
        chk("timeout_sticky", 32'(hazard_timeout), 32'd1);

        // Reset mid-stall with only r10 pending; WB after reset must not resurrect it.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        issue_wr(10);
        read_rs(10, 0, 0);
        read_rs(10, 0, 0);
        step(1, 1, 10, 0, 1, 0, 0, 0, 1, 10, 0);
        step(1, 1, 10, 0, 1, 0, 0, 0, 1, 10, 0);
        read_rs(10, 1, 10);
        read_rs(10, 0, 0);
        #2;
        chk("timeout_cleared", 32'(hazard_timeout), 32'd0);

        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                 ($urandom_range(0, 19) == 0));
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Scoreboard-based hazard controller for the 5-stage MIPS pipeline; sits beside the decode stage.
- Tracks one busy bit per architectural register, set when a writing instruction issues from ID and cleared at writeback.
- Drives IF/ID stall, EX bubble insertion and IF/ID flush on taken branches.
- Replaces ad-hoc stall flag handling in decode with one sequenced controller.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).
- STALL_TIMEOUT, 15, consecutive stall cycles before the watchdog fires.
- FLUSH_CYCLES, 1, number of cycles flush_if_id is held after a taken branch.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  AW  source register 1.
- id_rt  in  AW  source register 2.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes a register (control unit RegWrite).
- id_wr_addr  in  AW  destination after RegDst mux.
- wb_wr_en  in  1  WB stage writing the register file this cycle.
- wb_wr_addr  in  AW  WB destination.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold ID inputs.
- bubble_ex  out  1  inject NOP into ID/EX.
- flush_if_id  out  1  kill IF/ID contents.
- busy_vec  out  NREG  current scoreboard, bit i = register i pending.
- hazard_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async): busy_vec=0, state=RUN, stall counter=0, flush counter=0, hazard_timeout=0. All outputs are 0 while reset is high.
- Register 0:
  - Never marked busy.
  - Reads of r0 never hazard.
  - Writes to r0 are ignored at issue and at WB.
- hazard (combinational) = id_valid & ((id_rs_used & busy_vec[id_rs]) | (id_rt_used & busy_vec[id_rt])). It uses the registered busy_vec only.
- No same-cycle WB bypass: a consumer stalls through the WB cycle and proceeds the following cycle. Minimum RAW penalty is fixed by this rule.
- issue = id_valid & id_wr_en & ~hazard & state!=FLUSH & ~ex_branch_taken.
- Busy update each posedge:
  - Clear busy[wb_wr_addr] if wb_wr_en.
  - Then set busy[id_wr_addr] if issue.
  - Same-register set and clear in one cycle: set wins (new producer outstanding).
- States and transitions:
  - RUN: hazard -> STALL; ex_branch_taken -> FLUSH (priority over hazard).
  - STALL: ex_branch_taken -> FLUSH; ~hazard -> RUN; else stay.
  - FLUSH: flush counter counts FLUSH_CYCLES, then -> RUN; ex_branch_taken in FLUSH reloads the counter.
- Outputs (Mealy):
  - stall_if = stall_id = bubble_ex = hazard & state!=FLUSH & ~ex_branch_taken.
  - flush_if_id = (state==FLUSH).
  - In FLUSH the ID instruction is dead: no stall, no issue, no busy set.
- Stall counter:
  - Increments every cycle stall_if=1, saturating at STALL_TIMEOUT.
  - Cleared on any cycle with stall_if=0.
  - Reaching STALL_TIMEOUT sets hazard_timeout; it is cleared only by reset.
- Reset asserted mid-stall or mid-flush: immediate return to RUN with an empty scoreboard; in-flight WB writes after reset do not resurrect busy bits.

Decomposition:
- Shared package/include hazard_pkg:
  - State encodings ST_RUN=2'd0, ST_STALL=2'd1, ST_FLUSH=2'd2.
  - NREG/AW defaults.
- Sub-module scoreboard_regs:
  - Contains the NREG busy flops, r0 masking and set-over-clear priority.
  - Inputs: set_en/set_addr, clr_en/clr_addr. Output: busy_vec.
- FSM, counters and output logic live in the top.

Test Plan:
- RAW stall: issue write r5 at cycle 0, next instr reads r5 (rs_used=1) -> stall_if/bubble_ex=1 until the cycle after wb_wr_en/addr=5. Then stall drops, busy_vec[5]=0.
- r0 write and read: id_wr_addr=0 issued, then read rs=0 -> busy_vec stays 0, no stall.
- Same-cycle set/clear: wb clears r7 while ID issues write r7 -> busy_vec[7]=1 next cycle.
- Branch during stall:
  - Stall on r3, then ex_branch_taken=1 -> stall outputs 0 that cycle.
  - flush_if_id=1 for exactly 1 cycle (FLUSH_CYCLES=1), then RUN.
  - No busy bit set for the killed instruction.
- Watchdog: hold r9 busy with no WB for 15 stall cycles -> hazard_timeout rises on the 15th. It stays 1 after the stall clears, until reset.
- Reset mid-stall: busy_vec=0x00000400, state=STALL, reset pulsed asynchronously -> outputs 0 immediately, busy_vec=0, state=RUN after release.
